// File: rtl/seg7_frame_decoder.sv
// seg7_frame_decoder
//   Turns a stream of active-low seven-segment patterns (bit6 = a .. bit0 = g),
//   most significant digit first, back into a binary value.
//   A beat flagged last closes the frame. The block then presents the value,
//   the number of digits it accumulated and an error flag until the consumer
//   takes the result.
//   Optional feature macro: SEG7_BLANK_SKIP_EN. When it is defined, the blank
//   pattern 1111111 is accepted as a no-op beat instead of an invalid pattern.
module seg7_frame_decoder #(
    parameter int MAX_DIGITS = 3,   // maximum decimal digits per frame
    parameter int OUT_W      = 10   // 2**OUT_W must exceed 10**MAX_DIGITS - 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             seg_valid_i,
    output logic             seg_ready_o,
    input  logic [6:0]       seg_data_i,
    input  logic             seg_last_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [OUT_W-1:0] res_value_o,
    output logic [3:0]       res_digits_o,
    output logic             res_err_o
);

    // Four spare bits cover the x10 + d growth before truncation.
    localparam int         ACC_W   = OUT_W + 4;
    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_RESULT  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               pat_is_digit;
    logic               pat_is_blank;
    logic [3:0]         pat_digit;
    logic [ACC_W-1:0]   acc_ext;
    logic [ACC_W-1:0]   acc_mac;
    logic               beat_acc;
    logic               res_fire;

    // Pattern decode: active-low segment code to digit value plus a validity flag.
    always_comb begin
        pat_is_digit = 1'b1;
        pat_digit    = 4'd0;
        case (seg_data_i)
            7'b0000001: pat_digit = 4'd0;
            7'b1001111: pat_digit = 4'd1;
            7'b0010010: pat_digit = 4'd2;
            7'b0000110: pat_digit = 4'd3;
            7'b1001100: pat_digit = 4'd4;
            7'b0100100: pat_digit = 4'd5;
            7'b0100000: pat_digit = 4'd6;
            7'b0001111: pat_digit = 4'd7;
            7'b0000000: pat_digit = 4'd8;
            7'b0000100: pat_digit = 4'd9;
            default:    pat_is_digit = 1'b0;
        endcase
    end

`ifdef SEG7_BLANK_SKIP_EN
    // A fully dark digit is a blanked leading zero: accepted, but a no-op.
    assign pat_is_blank = (seg_data_i == 7'b1111111);
`else
    // Blank is just another pattern outside the table and flags an error.
    assign pat_is_blank = 1'b0;
`endif

    // acc*10 + d computed wide as (acc<<3) + (acc<<1) + d, then truncated.
    assign acc_ext = {4'b0000, acc_q};
    assign acc_mac = (acc_ext << 3) + (acc_ext << 1) + {{(ACC_W-4){1'b0}}, pat_digit};

    // Handshake qualifiers for both sides.
    assign beat_acc = seg_valid_i & seg_ready_o;
    assign res_fire = res_valid_o & res_ready_i;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_COLLECT;
        else       state_q <= state_d;
    end

    // Next-state: the last accepted beat closes the frame and the result handshake reopens it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COLLECT: if (beat_acc && seg_last_i) state_d = ST_RESULT;
            ST_RESULT:  if (res_ready_i)            state_d = ST_COLLECT;
            default:                                state_d = ST_COLLECT;
        endcase
    end

    // Outputs: pure state decode, so res_ready has no combinational path to seg_ready.
    always_comb begin
        seg_ready_o = (state_q == ST_COLLECT);
        res_valid_o = (state_q == ST_RESULT);
    end

    // Accumulator next-state. Overflow digits and bad patterns only raise err.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (beat_acc && !pat_is_blank) begin
            if (!pat_is_digit) begin
                err_d = 1'b1;
            end else if (cnt_q < MAX_CNT) begin
                acc_d = OUT_W'(acc_mac);
                cnt_d = cnt_q + 4'd1;
            end else begin
                err_d = 1'b1;
            end
        end
        if (res_fire) begin
            acc_d = '0;
            cnt_d = 4'd0;
            err_d = 1'b0;
        end
    end

    // Accumulator registers. Reset drops any partial frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            cnt_q <= 4'd0;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // The result fields are the live accumulator, which holds still while in RESULT.
    assign res_value_o  = acc_q;
    assign res_digits_o = cnt_q;
    assign res_err_o    = err_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Bench for seg7_frame_decoder: directed cases plus randomized frames checked
// against a reference model that decodes by searching the digit table.
module tb_seg7_frame_decoder;
    localparam int MAX_DIGITS = 3;
    localparam int OUT_W      = 10;
`ifdef SEG7_BLANK_SKIP_EN
    localparam bit BLANK_SKIP = 1'b1;
`else
    localparam bit BLANK_SKIP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             seg_valid = 1'b0;
    logic             seg_ready;
    logic [6:0]       seg_data = 7'h7f;
    logic             seg_last = 1'b0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [OUT_W-1:0] res_value;
    logic [3:0]       res_digits;
    logic             res_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg7_frame_decoder #(.MAX_DIGITS(MAX_DIGITS), .OUT_W(OUT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .seg_valid_i(seg_valid), .seg_ready_o(seg_ready),
        .seg_data_i(seg_data), .seg_last_i(seg_last),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_value_o(res_value), .res_digits_o(res_digits), .res_err_o(res_err)
    );

    // Forward encoding of each decimal digit to its display pattern.
    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b0000001;  1: return 7'b1001111;
            2: return 7'b0010010;  3: return 7'b0000110;
            4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;
            8: return 7'b0000000;  default: return 7'b0000100;
        endcase
    endfunction

    // Decode by table search; -1 means not a digit pattern.
    function automatic int dec(input logic [6:0] p);
        for (int d = 0; d < 10; d++) if (enc(d) == p) return d;
        return -1;
    endfunction

    // Expected result of a whole frame.
    function automatic void model(input logic [6:0] pats[$], output int v, output int dg, output bit e);
        int d;
        v = 0; dg = 0; e = 1'b0;
        foreach (pats[i]) begin
            if (BLANK_SKIP && pats[i] == 7'b1111111) continue;
            d = dec(pats[i]);
            if (d < 0) e = 1'b1;
            else if (dg >= MAX_DIGITS) e = 1'b1;
            else begin
                v = (v * 10 + d) % (1 << OUT_W);
                dg++;
            end
        end
    endfunction

    // Drive beats; the final one carries last when close is set. Entered and left at posedge+1.
    task automatic send_beats(input logic [6:0] pats[$], input bit close, input int gap_max);
        foreach (pats[i]) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            seg_valid = 1'b1;
            seg_data  = pats[i];
            seg_last  = close && (i == pats.size() - 1);
            @(posedge clk); #1;
            seg_valid = 1'b0;
            seg_last  = 1'b0;
        end
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 5;
        if (seg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_seg_ready got %b want 1", seg_ready); end
        if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        if (res_value !== '0)   begin n_bad++; $display("FAIL reset_value got %0d want 0", res_value); end
        if (res_digits !== 4'd0) begin n_bad++; $display("FAIL reset_digits got %0d want 0", res_digits); end
        if (res_err !== 1'b0)   begin n_bad++; $display("FAIL reset_err got %b want 0", res_err); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [6:0] f[$];
        int ev[4] = '{235, 8, 71, 123};
        int ed[4] = '{3, 1, 2, 3};
        bit ee[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: f = '{7'b0010010, 7'b0000110, 7'b0100100};
                1: f = '{7'b0000000};
                2: f = '{7'b0001111, 7'b1010101, 7'b1001111};
                default: f = '{enc(1), enc(2), enc(3), enc(4)};
            endcase
            send_beats(f, 1'b1, 0);
            n_cmp += 6;
            if (res_valid !== 1'b1) begin n_bad++; $display("FAIL vec%0d_latency res_valid got %b want 1", k, res_valid); end
            if (seg_ready !== 1'b0) begin n_bad++; $display("FAIL vec%0d_seg_ready got %b want 0", k, seg_ready); end
            if (res_value !== OUT_W'(ev[k])) begin n_bad++; $display("FAIL vec%0d_value got %0d want %0d", k, res_value, ev[k]); end
            if (res_digits !== 4'(ed[k])) begin n_bad++; $display("FAIL vec%0d_digits got %0d want %0d", k, res_digits, ed[k]); end
            if (res_err !== ee[k]) begin n_bad++; $display("FAIL vec%0d_err got %b want %b", k, res_err, ee[k]); end
            consume();
            if (seg_ready !== 1'b1 || res_valid !== 1'b0) begin
                n_bad++; $display("FAIL vec%0d_release seg_ready=%b res_valid=%b want 1/0", k, seg_ready, res_valid);
            end
        end
    endtask

    task automatic test_hold();
        logic [6:0] f[$];
        f = '{enc(4), enc(2)};
        send_beats(f, 1'b1, 0);
        // Offer a junk beat the whole time the result is pending.
        seg_valid = 1'b1; seg_data = enc(7); seg_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp += 3;
            if (res_valid !== 1'b1 || seg_ready !== 1'b0) begin
                n_bad++; $display("FAIL hold%0d_handshake res_valid=%b seg_ready=%b want 1/0", c, res_valid, seg_ready);
            end
            if (res_value !== OUT_W'(42) || res_digits !== 4'd2) begin
                n_bad++; $display("FAIL hold%0d_value got %0d/%0d want 42/2", c, res_value, res_digits);
            end
            if (res_err !== 1'b0) begin n_bad++; $display("FAIL hold%0d_err got %b want 0", c, res_err); end
        end
        seg_valid = 1'b0; seg_last = 1'b0;
        consume();
        n_cmp += 2;
        if (seg_ready !== 1'b1) begin n_bad++; $display("FAIL hold_release seg_ready got %b want 1", seg_ready); end
        if (res_value !== '0 || res_digits !== 4'd0 || res_err !== 1'b0) begin
            n_bad++; $display("FAIL hold_clear got %0d/%0d/%b want 0/0/0", res_value, res_digits, res_err);
        end
        f = '{enc(5)};
        send_beats(f, 1'b1, 0);
        n_cmp++;
        if (res_valid !== 1'b1 || res_value !== OUT_W'(5) || res_digits !== 4'd1 || res_err !== 1'b0) begin
            n_bad++; $display("FAIL hold_next got v=%b %0d/%0d/%b want 1 5/1/0", res_valid, res_value, res_digits, res_err);
        end
        consume();
    endtask

    task automatic test_midframe_reset();
        logic [6:0] f[$];
        bit eb;
        f = '{enc(1), enc(2)};
        send_beats(f, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        n_cmp += 2;
        if (res_value !== '0 || res_digits !== 4'd0 || res_err !== 1'b0) begin
            n_bad++; $display("FAIL rst_async_clear got %0d/%0d/%b want 0/0/0", res_value, res_digits, res_err);
        end
        if (res_valid !== 1'b0 || seg_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_async_hs res_valid=%b seg_ready=%b want 0/1", res_valid, seg_ready);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        f = '{enc(9)};
        send_beats(f, 1'b1, 0);
        n_cmp++;
        if (res_valid !== 1'b1 || res_value !== OUT_W'(9) || res_digits !== 4'd1 || res_err !== 1'b0) begin
            n_bad++; $display("FAIL rst_next got v=%b %0d/%0d/%b want 1 9/1/0", res_valid, res_value, res_digits, res_err);
        end
        consume();
        f = '{7'b1111111, 7'b1111111, enc(7)};
        eb = !BLANK_SKIP;
        send_beats(f, 1'b1, 0);
        n_cmp++;
        if (res_valid !== 1'b1 || res_value !== OUT_W'(7) || res_digits !== 4'd1 || res_err !== eb) begin
            n_bad++; $display("FAIL blank_frame got v=%b %0d/%0d/%b want 1 7/1/%b", res_valid, res_value, res_digits, res_err, eb);
        end
        consume();
        // A lone blank carrying last still closes the frame.
        f = '{7'b1111111};
        send_beats(f, 1'b1, 0);
        n_cmp++;
        if (res_valid !== 1'b1 || res_value !== '0 || res_digits !== 4'd0 || res_err !== eb) begin
            n_bad++; $display("FAIL blank_last got v=%b %0d/%0d/%b want 1 0/0/%b", res_valid, res_value, res_digits, res_err, eb);
        end
        consume();
    endtask

    function automatic logic [6:0] rand_pat();
        int r = $urandom_range(0, 99);
        if (r < 70) return enc($urandom_range(0, 9));
        if (r < 85) return 7'b1111111;
        return 7'($urandom);
    endfunction

    task automatic test_random();
        logic [6:0] f[$];
        int v, dg, w;
        bit e;
        for (int n = 0; n < 60; n++) begin
            f.delete();
            repeat ($urandom_range(1, 5)) f.push_back(rand_pat());
            model(f, v, dg, e);
            send_beats(f, 1'b1, 2);
            n_cmp++;
            if (res_valid !== 1'b1 || res_value !== OUT_W'(v) || res_digits !== 4'(dg) || res_err !== e) begin
                n_bad++; $display("FAIL rand%0d got v=%b %0d/%0d/%b want 1 %0d/%0d/%b", n, res_valid, res_value, res_digits, res_err, v, dg, e);
            end
            w = $urandom_range(0, 3);
            repeat (w) begin @(posedge clk); #1; end
            n_cmp++;
            if (res_valid !== 1'b1 || res_value !== OUT_W'(v)) begin
                n_bad++; $display("FAIL rand%0d_hold got v=%b %0d want 1 %0d", n, res_valid, res_value, v);
            end
            consume();
            n_cmp++;
            if (seg_ready !== 1'b1 || res_valid !== 1'b0) begin
                n_bad++; $display("FAIL rand%0d_release seg_ready=%b res_valid=%b want 1/0", n, seg_ready, res_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] f[$];
        int v, dg;
        bit e;
        res_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            f.delete();
            repeat ($urandom_range(1, 4)) f.push_back(rand_pat());
            model(f, v, dg, e);
            send_beats(f, 1'b1, 0);
            n_cmp++;
            if (res_valid !== 1'b1 || res_value !== OUT_W'(v) || res_digits !== 4'(dg) || res_err !== e) begin
                n_bad++; $display("FAIL b2b%0d got v=%b %0d/%0d/%b want 1 %0d/%0d/%b", n, res_valid, res_value, res_digits, res_err, v, dg, e);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (res_valid !== 1'b0 || seg_ready !== 1'b1) begin
                n_bad++; $display("FAIL b2b%0d_dead res_valid=%b seg_ready=%b want 0/1", n, res_valid, seg_ready);
            end
        end
        res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_midframe_reset();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
